mbist_march_y_ctrl: RTL and testbench

Parametrised March Y memory BIST controller. It is the next generation of the fixed 8-bit/16-word MBIST controller: width, depth, read latency and data background are all configurable. It adds a start/done handshake, a pipelined read comparator, first-fail capture, a saturating fail counter and an optional stop-on-fail mode. The block drives an external single-port synchronous SRAM and sits between the SoC test-control logic and that memory.

---
 rtl/mbist_march_y_ctrl_if.sv | 31 +++
 rtl/mbist_march_y_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mbist_march_y_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_march_y_ctrl_if.sv
`timescale 1ns/1ps
// Memory-side bus of the March Y BIST controller: address, strobes and data to a single-port SRAM.
// Latency: none, this is wiring only; read data returns RD_LAT cycles after the read strobe.
// Backpressure: none, the SRAM accepts one op every cycle.
interface mbist_march_y_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Controller side drives the op, memory side returns read data.
    modport master (
        output mem_addr,
        output mem_we,
        output mem_re,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_re,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mbist_march_y_ctrl.sv
`timescale 1ns/1ps
// March Y memory BIST: runs w0 / up(r0,w1,r1) / down(r1,w0,r0) / r0 against a sync SRAM, logs first fail.
// Latency: first op one cycle after start; done 8*2^AW + RD_LAT + 1 cycles after start.
// Backpressure: none; start is ignored while busy, stop_on_fail drains outstanding reads early.
module mbist_march_y_ctrl #(
    parameter int             DW     = 8,
    parameter int             AW     = 4,
    parameter int             RD_LAT = 1,
    parameter logic [DW-1:0]  BG     = {DW{1'b0}},
    parameter int             CNTW   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop_on_fail,
    mbist_march_y_ctrl_if.master mem,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [1:0]          element,
    output logic [AW-1:0]       fail_addr,
    output logic [DW-1:0]       fail_exp,
    output logic [DW-1:0]       fail_act,
    output logic [CNTW-1:0]     fail_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_M0,
        S_M1,
        S_M2,
        S_M3,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] ADDR_MAX   = '1;
    localparam logic [1:0]    DRAIN_LAST = 2'(RD_LAT - 1);

    state_t        state_q, nxt_state;
    logic [AW-1:0] addr_q, nxt_addr;
    logic [1:0]    op_q, nxt_op;
    logic [1:0]    drain_q, nxt_drain;
    logic          stop_q;
    logic          start_acc;

    // Op decode for the next cycle; nxt_one selects ~BG instead of BG.
    logic          nxt_we, nxt_re, nxt_one;
    logic [DW-1:0] nxt_pat;
    logic [1:0]    nxt_element;

    // Registered memory op and the expected data travelling with a read.
    logic          we_q, re_q;
    logic [DW-1:0] wdata_q, rexp_q;

    // Compare pipe: stage RD_LAT-1 lines up with the returning read data.
    logic          pipe_vld  [RD_LAT];
    logic [AW-1:0] pipe_addr [RD_LAT];
    logic [DW-1:0] pipe_exp  [RD_LAT];
    logic          cmp_vld, mismatch;
    logic          fail_seen;

    assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE);
    assign cmp_vld   = pipe_vld[RD_LAT-1];
    assign mismatch  = cmp_vld && (mem.mem_rdata != pipe_exp[RD_LAT-1]);

    assign mem.mem_addr  = addr_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_re    = re_q;
    assign mem.mem_wdata = wdata_q;

    // Next state: walk elements and addresses, cut to DRAIN on a fail when stopping is enabled.
    always_comb begin
        nxt_state = state_q;
        nxt_addr  = addr_q;
        nxt_op    = op_q;
        nxt_drain = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    nxt_state = S_M0;
                    nxt_addr  = '0;
                    nxt_op    = '0;
                end
            end
            S_M0: begin
                if (addr_q == ADDR_MAX) begin
                    nxt_state = S_M1;
                    nxt_addr  = '0;
                end else begin
                    nxt_addr = addr_q + AW'(1);
                end
            end
            S_M1: begin
                if (op_q == 2'd2) begin
                    nxt_op = '0;
                    if (addr_q == ADDR_MAX) begin
                        nxt_state = S_M2;
                        nxt_addr  = ADDR_MAX;
                    end else begin
                        nxt_addr = addr_q + AW'(1);
                    end
                end else begin
                    nxt_op = op_q + 2'd1;
                end
            end
            S_M2: begin
                if (op_q == 2'd2) begin
                    nxt_op = '0;
                    if (addr_q == '0) begin
                        nxt_state = S_M3;
                        nxt_addr  = '0;
                    end else begin
                        nxt_addr = addr_q - AW'(1);
                    end
                end else begin
                    nxt_op = op_q + 2'd1;
                end
            end
            S_M3: begin
                if (addr_q == ADDR_MAX) begin
                    nxt_state = S_DRAIN;
                end else begin
                    nxt_addr = addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    nxt_state = S_DONE;
                end else begin
                    nxt_drain = drain_q + 2'd1;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
        if (stop_q && mismatch && (state_q inside {S_M0, S_M1, S_M2, S_M3})) begin
            nxt_state = S_DRAIN;
            nxt_addr  = addr_q;
            nxt_op    = op_q;
            nxt_drain = '0;
        end
    end

    // Decode the op that the next state will issue, plus the element number to report.
    always_comb begin
        nxt_we      = 1'b0;
        nxt_re      = 1'b0;
        nxt_one     = 1'b0;
        nxt_element = element;
        case (nxt_state)
            S_IDLE: nxt_element = 2'd0;
            S_M0: begin
                nxt_we      = 1'b1;
                nxt_element = 2'd0;
            end
            S_M1: begin
                nxt_element = 2'd1;
                nxt_we      = (nxt_op == 2'd1);
                nxt_re      = (nxt_op != 2'd1);
                nxt_one     = (nxt_op != 2'd0);
            end
            S_M2: begin
                nxt_element = 2'd2;
                nxt_we      = (nxt_op == 2'd1);
                nxt_re      = (nxt_op != 2'd1);
                nxt_one     = (nxt_op == 2'd0);
            end
            S_M3: begin
                nxt_re      = 1'b1;
                nxt_element = 2'd3;
            end
            default: ;
        endcase
        nxt_pat = nxt_one ? ~BG : BG;
    end

    // State register; stop_on_fail is latched only when a run is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            op_q    <= '0;
            drain_q <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= nxt_state;
            addr_q  <= nxt_addr;
            op_q    <= nxt_op;
            drain_q <= nxt_drain;
            if (start_acc) begin
                stop_q <= stop_on_fail;
            end
        end
    end

    // Registered memory strobes and status; pass folds in a fail seen on the final compare edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            wdata_q <= '0;
            rexp_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            element <= 2'd0;
        end else begin
            we_q    <= nxt_we;
            re_q    <= nxt_re;
            if (nxt_we) begin
                wdata_q <= nxt_pat;
            end
            if (nxt_re) begin
                rexp_q <= nxt_pat;
            end
            busy    <= nxt_state inside {S_M0, S_M1, S_M2, S_M3, S_DRAIN};
            done    <= (nxt_state == S_DONE);
            pass    <= (nxt_state == S_DONE) && !(fail_seen || mismatch);
            element <= nxt_element;
        end
    end

    // Shift each issued read's address and expected data toward the compare stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_addr[i] <= '0;
                pipe_exp[i]  <= '0;
            end
        end else begin
            pipe_vld[0]  <= re_q;
            pipe_addr[0] <= addr_q;
            pipe_exp[0]  <= rexp_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
            end
        end
    end

    // Fail log: count every mismatch (saturating), capture details of the first one only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_seen <= 1'b0;
            fail_cnt  <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
        end else if (start_acc) begin
            fail_seen <= 1'b0;
            fail_cnt  <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
        end else if (mismatch) begin
            if (fail_cnt != '1) begin
                fail_cnt <= fail_cnt + CNTW'(1);
            end
            if (!fail_seen) begin
                fail_seen <= 1'b1;
                fail_addr <= pipe_addr[RD_LAT-1];
                fail_exp  <= pipe_exp[RD_LAT-1];
                fail_act  <= mem.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mbist_march_y_ctrl.sv
`timescale 1ns/1ps
// Bench for the March Y BIST: two configurations against behavioural SRAMs with an optional stuck bit.
// Latency: expected done latency and op counts per run are queued at stimulus time.
// Backpressure: none; monitors pop one expectation per rising done.
module tb_mbist_march_y_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start_a, stop_a, start_b, stop_b;
    logic fault_a;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Configuration A: 8 bit x 16 words, RD_LAT 1, BG 0.
    mbist_march_y_ctrl_if #(.DW(8), .AW(4)) bus_a();
    logic       busy_a, done_a, pass_a;
    logic [1:0] elem_a;
    logic [3:0] faddr_a;
    logic [7:0] fexp_a, fact_a, fcnt_a;

    mbist_march_y_ctrl #(.DW(8), .AW(4), .RD_LAT(1), .BG(8'h00), .CNTW(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop_on_fail(stop_a), .mem(bus_a.master),
        .busy(busy_a), .done(done_a), .pass(pass_a), .element(elem_a),
        .fail_addr(faddr_a), .fail_exp(fexp_a), .fail_act(fact_a), .fail_cnt(fcnt_a)
    );

    // Configuration B: 8 bit x 8 words, RD_LAT 2, BG A5.
    mbist_march_y_ctrl_if #(.DW(8), .AW(3)) bus_b();
    logic       busy_b, done_b, pass_b;
    logic [1:0] elem_b;
    logic [2:0] faddr_b;
    logic [7:0] fexp_b, fact_b, fcnt_b;

    mbist_march_y_ctrl #(.DW(8), .AW(3), .RD_LAT(2), .BG(8'hA5), .CNTW(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop_on_fail(stop_b), .mem(bus_b.master),
        .busy(busy_b), .done(done_b), .pass(pass_b), .element(elem_b),
        .fail_addr(faddr_b), .fail_exp(fexp_b), .fail_act(fact_b), .fail_cnt(fcnt_b)
    );

    // SRAM A: write-through, one-cycle read, optional bit 3 stuck-at-0 at address 5.
    logic [7:0] mem_a [16];
    logic [7:0] rp_a;
    always @(posedge clk) begin
        if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
        if (bus_a.mem_re) rp_a <= (fault_a && bus_a.mem_addr == 4'd5) ?
                                  (mem_a[bus_a.mem_addr] & 8'hF7) : mem_a[bus_a.mem_addr];
    end
    assign bus_a.mem_rdata = rp_a;

    // SRAM B: two-cycle read.
    logic [7:0] mem_b [8];
    logic [7:0] rp_b0, rp_b1;
    always @(posedge clk) begin
        if (bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        if (bus_b.mem_re) rp_b0 <= mem_b[bus_b.mem_addr];
        rp_b1 <= rp_b0;
    end
    assign bus_b.mem_rdata = rp_b1;

    typedef struct {
        logic       pass;
        logic [7:0] cnt;
        logic [3:0] faddr;
        logic [7:0] fexp;
        logic [7:0] fact;
        int         lat;
        int         nwe;
        int         nre;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor A: tracks each accepted run, checks its first op, and scores it at done.
    initial begin
        bit act = 0, dprev = 0;
        int ts = 0, nwe = 0, nre = 0, both = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 0; dprev = 0;
                continue;
            end
            if (act) begin
                if (cyc == ts + 1) begin
                    chk("a_first_we", bus_a.mem_we, 1);
                    chk("a_first_addr", bus_a.mem_addr, 0);
                    chk("a_first_wdata", bus_a.mem_wdata, 8'h00);
                    chk("a_first_cnt", fcnt_a, 0);
                    chk("a_first_done", done_a, 0);
                    chk("a_first_busy", busy_a, 1);
                end
                nwe += int'(bus_a.mem_we);
                nre += int'(bus_a.mem_re);
                if (bus_a.mem_we && bus_a.mem_re) both++;
            end
            if (done_a && !dprev) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_done", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    chk("a_pass", pass_a, e.pass);
                    chk("a_fail_cnt", fcnt_a, e.cnt);
                    chk("a_fail_addr", faddr_a, e.faddr);
                    chk("a_fail_exp", fexp_a, e.fexp);
                    chk("a_fail_act", fact_a, e.fact);
                    chk("a_busy_at_done", busy_a, 0);
                    chk("a_latency", cyc - ts, e.lat);
                    chk("a_n_we", nwe, e.nwe);
                    chk("a_n_re", nre, e.nre);
                    chk("a_we_re_overlap", both, 0);
                end
                act = 0;
            end
            dprev = done_a;
            if (start_a && !busy_a) begin
                act = 1; ts = cyc; nwe = 0; nre = 0; both = 0;
            end
        end
    end

    // Monitor B: same scoring, plus the background pattern of every write per element.
    initial begin
        bit act = 0, dprev = 0;
        int ts = 0, nwe = 0, nre = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 0; dprev = 0;
                continue;
            end
            if (act) begin
                if (bus_b.mem_we)
                    chk("b_wdata", bus_b.mem_wdata, (nwe >= 8 && nwe < 16) ? 8'h5A : 8'hA5);
                nwe += int'(bus_b.mem_we);
                nre += int'(bus_b.mem_re);
            end
            if (done_b && !dprev) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_done", 1, 0);
                end else begin
                    e = q_b.pop_front();
                    chk("b_pass", pass_b, e.pass);
                    chk("b_fail_cnt", fcnt_b, e.cnt);
                    chk("b_busy_at_done", busy_b, 0);
                    chk("b_latency", cyc - ts, e.lat);
                    chk("b_n_we", nwe, e.nwe);
                    chk("b_n_re", nre, e.nre);
                end
                act = 0;
            end
            dprev = done_b;
            if (start_b && !busy_b) begin
                act = 1; ts = cyc; nwe = 0; nre = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic stop);
        step();
        start_a = 1'b1; stop_a = stop;
        step();
        start_a = 1'b0; stop_a = 1'b0;
    endtask

    task automatic wait_a(input int left, input int bound);
        for (int i = 0; i < bound && q_a.size() > left; i++) @(negedge clk);
        if (q_a.size() > left) begin
            chk("a_done_timeout", q_a.size(), left);
            q_a.delete();
        end
        repeat (2) step();
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_pass"}, pass_a, 0);
        chk({tag, "_elem"}, elem_a, 0);
        chk({tag, "_faddr"}, faddr_a, 0);
        chk({tag, "_fexp"}, fexp_a, 0);
        chk({tag, "_fact"}, fact_a, 0);
        chk({tag, "_fcnt"}, fcnt_a, 0);
        chk({tag, "_we_re"}, {bus_a.mem_we, bus_a.mem_re}, 0);
        chk({tag, "_addr"}, bus_a.mem_addr, 0);
        chk({tag, "_wdata"}, bus_a.mem_wdata, 0);
    endtask

    //                        pass cnt   addr  exp    act    lat  we  re
    localparam exp_t E_CLEAN = '{1'b1, 8'd0, 4'd0, 8'h00, 8'h00, 130, 48, 80};
    localparam exp_t E_FAULT = '{1'b0, 8'd2, 4'd5, 8'hFF, 8'hF7, 130, 48, 80};
    localparam exp_t E_STOP  = '{1'b0, 8'd1, 4'd5, 8'hFF, 8'hF7, 37, 22, 13};
    localparam exp_t E_B     = '{1'b1, 8'd0, 4'd0, 8'h00, 8'h00, 67, 24, 40};

    initial begin
        rst = 1'b1; start_a = 0; stop_a = 0; start_b = 0; stop_b = 0; fault_a = 0;
        repeat (3) @(negedge clk);
        chk_zero_a("rst_hold");
        chk("rst_hold_b_busy", busy_b, 0);
        chk("rst_hold_b_done", done_b, 0);
        step();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_a("rst_idle");

        // Fault-free run with a stray start in the middle that must be ignored.
        q_a.push_back(E_CLEAN);
        pulse_a(1'b0);
        repeat (48) step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_a(0, 300);

        // Stuck bit, keep running.
        fault_a = 1'b1;
        q_a.push_back(E_FAULT);
        pulse_a(1'b0);
        wait_a(0, 300);

        // Stuck bit, stop on first fail.
        q_a.push_back(E_STOP);
        pulse_a(1'b1);
        wait_a(0, 300);

        // Start held through DONE: immediate restart with the fail log cleared.
        q_a.push_back(E_FAULT);
        q_a.push_back(E_FAULT);
        step();
        start_a = 1'b1;
        wait_a(1, 300);
        start_a = 1'b0;
        wait_a(0, 300);

        // Reset in the middle of M2, then a clean full run.
        fault_a = 1'b0;
        pulse_a(1'b0);
        for (int i = 0; i < 300 && !(elem_a == 2'd2 && bus_a.mem_addr == 4'd9); i++) @(negedge clk);
        chk("a_reached_m2_addr9", {elem_a, bus_a.mem_addr}, {2'd2, 4'd9});
        @(posedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        chk_zero_a("rst_mid");
        q_a.push_back(E_CLEAN);
        pulse_a(1'b0);
        wait_a(0, 300);

        // Configuration B, fault-free.
        q_b.push_back(E_B);
        step();
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 200 && q_b.size() > 0; i++) @(negedge clk);
        if (q_b.size() > 0) begin
            chk("b_done_timeout", q_b.size(), 0);
            q_b.delete();
        end
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
